// File: rtl/spi_fifo_burst_rd.sv
// Read-side burst controller: after a post-reset warm-up it drains BURST_WORDS FIFO words and shifts each
// out MSB-first on sclk/sdo under cs_n. Optional macro SPI_FIFO_BURST_UNDERRUN_ABORT_EN aborts on an empty FIFO.
module spi_fifo_burst_rd #(
    parameter int DW             = 8,
    parameter int BURST_WORDS    = 1024,
    parameter int STARTUP_CYCLES = 14,
    parameter int GAP_CYCLES     = 1
) (
    input  logic          RCLOCK,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_aempty,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_q,
    output logic          fifo_re,
    output logic          sclk,
    output logic          sdo,
    output logic          cs_n,
    output logic          busy,
    output logic          burst_done,
    output logic          ready
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
   ,output logic          underrun
`endif
);

    localparam int WW   = $clog2(BURST_WORDS + 1);
    localparam int BW   = $clog2(2 * DW);
    localparam int CMAX = (STARTUP_CYCLES > GAP_CYCLES) ? STARTUP_CYCLES : GAP_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [WW-1:0] WORD_LAST = WW'(BURST_WORDS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(2 * DW - 1);
    localparam logic [CW-1:0] WARM_LAST = CW'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {WARMUP, IDLE, READ, LOAD, SHIFT, GAP, DONE} state_t;

    state_t        state_q;
    logic [WW-1:0] word_q;
    logic [BW-1:0] bit_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] shift_q;
    logic          sclk_q;
    logic          sdo_q;
    logic          cs_n_q;
    logic          busy_q;
    logic          done_q;
    logic          ready_q;
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
    logic          underrun_q;
`endif

    logic [WW-1:0] word_d;
    logic [DW-1:0] shift_d;

    // NOTE: every variable assigned in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        word_d  = word_q + 1'b1;
        shift_d = shift_q << 1;
    end

    // The read strobe follows the registered state so the FIFO sees it in the same cycle as READ.
    assign fifo_re    = (state_q == READ) && !fifo_empty;
    assign sclk       = sclk_q;
    assign sdo        = sdo_q;
    assign cs_n       = cs_n_q;
    assign busy       = busy_q;
    assign burst_done = done_q;
    assign ready      = ready_q;
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
    assign underrun   = underrun_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge RCLOCK or negedge rst) begin
        if (!rst) begin
            state_q    <= WARMUP;
            word_q     <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            sclk_q     <= 1'b0;
            sdo_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
            underrun_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                WARMUP: begin
                    if (cnt_q == WARM_LAST) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                IDLE: begin
                    if (en && !fifo_aempty) begin
                        state_q <= READ;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        word_q  <= '0;
                    end
                end

                READ: begin
                    if (!fifo_empty) begin
                        state_q <= LOAD;
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
                    end else begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        cs_n_q     <= 1'b1;
                        underrun_q <= 1'b1;
`endif
                    end
                end

                LOAD: begin
                    shift_q <= fifo_q;
                    sdo_q   <= fifo_q[DW-1];
                    sclk_q  <= 1'b0;
                    bit_q   <= '0;
                    state_q <= SHIFT;
                end

                SHIFT: begin
                    if (bit_q == BIT_LAST) begin
                        sclk_q <= 1'b0;
                        word_q <= word_d;
                        if (word_d == WORD_LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            cs_n_q  <= 1'b1;
                        end else if (GAP_CYCLES == 0) begin
                            state_q <= READ;
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= '0;
                        end
                    end else begin
                        bit_q <= bit_q + 1'b1;
                        // Even phase -> raise sclk with sdo held; odd phase -> drop sclk and present the next bit.
                        if (!bit_q[0]) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q  <= 1'b0;
                            shift_q <= shift_d;
                            sdo_q   <= shift_d[DW-1];
                        end
                    end
                end

                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= READ;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fifo_burst_rd.sv
// Directed bench: instance A (DW=8, 4-word bursts, 14-cycle warm-up, 2-cycle gap) and
// instance B (DW=1, single-word bursts, no warm-up, no gap).
module tb_spi_fifo_burst_rd;

    logic RCLOCK = 1'b0;
    always #5 RCLOCK = ~RCLOCK;

    int checks = 0;
    int errors = 0;

    // Instance A
    logic       rst, en, fifo_aempty, fifo_empty;
    logic [7:0] fifo_q = '0;
    logic       fifo_re, sclk, sdo, cs_n, busy, burst_done, ready;
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
    logic       underrun;
`endif

    // Instance B
    logic       rst_b, en_b, aempty_b, empty_b;
    logic [0:0] q_b = '0;
    logic [0:0] data_b = 1'b1;
    logic       re_b, sclk_b, sdo_b, cs_n_b, busy_b, done_b, ready_b;
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
    logic       underrun_b;
`endif

    spi_fifo_burst_rd #(.DW(8), .BURST_WORDS(4), .STARTUP_CYCLES(14), .GAP_CYCLES(2)) dut_a (
        .RCLOCK(RCLOCK), .rst(rst), .en(en), .fifo_aempty(fifo_aempty), .fifo_empty(fifo_empty),
        .fifo_q(fifo_q), .fifo_re(fifo_re), .sclk(sclk), .sdo(sdo), .cs_n(cs_n), .busy(busy),
        .burst_done(burst_done), .ready(ready)
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
       ,.underrun(underrun)
`endif
    );

    spi_fifo_burst_rd #(.DW(1), .BURST_WORDS(1), .STARTUP_CYCLES(0), .GAP_CYCLES(0)) dut_b (
        .RCLOCK(RCLOCK), .rst(rst_b), .en(en_b), .fifo_aempty(aempty_b), .fifo_empty(empty_b),
        .fifo_q(q_b), .fifo_re(re_b), .sclk(sclk_b), .sdo(sdo_b), .cs_n(cs_n_b), .busy(busy_b),
        .burst_done(done_b), .ready(ready_b)
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
       ,.underrun(underrun_b)
`endif
    );

    // FIFO models with one-cycle registered read data
    logic [7:0] mem [0:63];
    int rd_ptr = 0;
    always @(posedge RCLOCK) begin
        if (fifo_re) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
        if (re_b) q_b <= data_b;
    end

    // Burst observations collected by run_burst
    int         re_times[$];
    logic [7:0] rx_words[$];
    int         cs_low, done_t, rises, hold_err, stall_bad;

    // Starts a burst from IDLE and records one sample per cycle (t=0 is the first READ cycle).
    task automatic run_burst(input int stall_t, input int stall_len, input int ae_t);
        logic       prev_sclk, prev_sdo;
        logic [7:0] sh;
        int         nb;
        re_times.delete();
        rx_words.delete();
        cs_low = 0; done_t = -1; rises = 0; hold_err = 0; stall_bad = 0;
        prev_sclk = sclk; prev_sdo = sdo; sh = '0; nb = 0;
        en = 1'b1; fifo_aempty = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge RCLOCK); #1;
            fifo_empty  = (t >= stall_t) && (t < stall_t + stall_len);
            fifo_aempty = (t >= ae_t);
            #1;
            if (fifo_re) re_times.push_back(t);
            if (!cs_n) cs_low++;
            if (sclk && !prev_sclk) begin
                sh = {sh[6:0], sdo};
                nb++;
                rises++;
                if (nb == 8) begin
                    rx_words.push_back(sh);
                    nb = 0;
                end
            end
            if (sclk && (sdo !== prev_sdo)) hold_err++;
            if (fifo_empty && (sclk !== 1'b0 || cs_n !== 1'b0 || fifo_re !== 1'b0)) stall_bad++;
            if (burst_done) begin
                done_t = t;
                break;
            end
            prev_sclk = sclk;
            prev_sdo  = sdo;
        end
        en = 1'b0; fifo_empty = 1'b0; fifo_aempty = 1'b0;
    endtask

    task automatic test_reset;
        logic [6:0] got;
        repeat (3) @(posedge RCLOCK);
        #2;
        got = {fifo_re, sclk, sdo, cs_n, busy, burst_done, ready};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL reset_a: got %b expected %b", got, 7'b0001000);
        end
        got = {re_b, sclk_b, sdo_b, cs_n_b, busy_b, done_b, ready_b};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL reset_b: got %b expected %b", got, 7'b0001000);
        end
    endtask

    task automatic test_edge_params;
        logic [5:0] exp_v [6];
        logic [5:0] got;
        logic [2:0] idle_v;
        exp_v[0] = 6'b100010;  // READ
        exp_v[1] = 6'b000010;  // LOAD
        exp_v[2] = 6'b001010;  // SHIFT phase 0
        exp_v[3] = 6'b011010;  // SHIFT phase 1
        exp_v[4] = 6'b001111;  // DONE
        exp_v[5] = 6'b001100;  // IDLE
        rst_b = 1'b1;
        checks++;
        if (ready_b !== 1'b0) begin
            errors++; $display("FAIL edge_ready_before_clock: got %b expected 0", ready_b);
        end
        @(posedge RCLOCK); #2;
        checks++;
        if (ready_b !== 1'b1) begin
            errors++; $display("FAIL edge_ready_first_clock: got %b expected 1", ready_b);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge RCLOCK); #2;
            idle_v = {re_b, busy_b, cs_n_b};
            checks++;
            if (idle_v !== 3'b001) begin
                errors++; $display("FAIL edge_no_start_en0 cycle %0d: got %b expected 001", i, idle_v);
            end
        end
        en_b = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(posedge RCLOCK); #1;
            en_b = 1'b0;
            #1;
            got = {re_b, sclk_b, sdo_b, cs_n_b, busy_b, done_b};
            checks++;
            if (got !== exp_v[t]) begin
                errors++; $display("FAIL edge_word cycle %0d: got %b expected %b", t, got, exp_v[t]);
            end
        end
    endtask

    task automatic test_warmup;
        logic exp_ready;
        rst = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge RCLOCK); #2;
            exp_ready = (k == 14);
            checks++;
            if (ready !== exp_ready) begin
                errors++; $display("FAIL warmup_ready cycle %0d: got %b expected %b", k, ready, exp_ready);
            end
            checks++;
            if (fifo_re !== 1'b0) begin
                errors++; $display("FAIL warmup_no_read cycle %0d: got %b expected 0", k, fifo_re);
            end
        end
    endtask

    task automatic test_basic_burst;
        int base;
        logic [2:0] got;
        base = rd_ptr;
        run_burst(1000, 0, 1000);
        checks++;
        if (re_times.size() != 4) begin
            errors++; $display("FAIL basic_read_count: got %0d expected 4", re_times.size());
        end
        foreach (re_times[i]) begin
            checks++;
            if (re_times[i] != 20 * i) begin
                errors++; $display("FAIL basic_read_time %0d: got %0d expected %0d", i, re_times[i], 20 * i);
            end
        end
        checks++;
        if (rx_words.size() != 4) begin
            errors++; $display("FAIL basic_word_count: got %0d expected 4", rx_words.size());
        end
        foreach (rx_words[i]) begin
            checks++;
            if (rx_words[i] !== mem[base+i]) begin
                errors++; $display("FAIL basic_word %0d: got %h expected %h", i, rx_words[i], mem[base+i]);
            end
        end
        checks++;
        if (cs_low != 78) begin
            errors++; $display("FAIL basic_cs_low: got %0d expected 78", cs_low);
        end
        checks++;
        if (done_t != 78) begin
            errors++; $display("FAIL basic_done_time: got %0d expected 78", done_t);
        end
        checks++;
        if (rises != 32) begin
            errors++; $display("FAIL basic_sclk_rises: got %0d expected 32", rises);
        end
        checks++;
        if (hold_err != 0) begin
            errors++; $display("FAIL basic_sdo_hold: got %0d changes expected 0", hold_err);
        end
        @(posedge RCLOCK); #2;
        got = {busy, burst_done, cs_n};
        checks++;
        if (got !== 3'b001) begin
            errors++; $display("FAIL basic_after_done: got %b expected 001", got);
        end
        @(posedge RCLOCK); #2;
        checks++;
        if ({fifo_re, busy} !== 2'b00) begin
            errors++; $display("FAIL basic_no_restart: got %b expected 00", {fifo_re, busy});
        end
    endtask

    task automatic test_underrun;
        int base, exp_done, exp_words;
        int exp_re[$];
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
        exp_re = '{0, 20}; exp_done = 41; exp_words = 2;
`else
        exp_re = '{0, 20, 45, 65}; exp_done = 83; exp_words = 4;
`endif
        base = rd_ptr;
        run_burst(40, 5, 1000);
        checks++;
        if (re_times.size() != exp_re.size()) begin
            errors++; $display("FAIL underrun_read_count: got %0d expected %0d", re_times.size(), exp_re.size());
        end
        foreach (re_times[i]) begin
            if (i < exp_re.size()) begin
                checks++;
                if (re_times[i] != exp_re[i]) begin
                    errors++; $display("FAIL underrun_read_time %0d: got %0d expected %0d", i, re_times[i], exp_re[i]);
                end
            end
        end
        checks++;
        if (rx_words.size() != exp_words) begin
            errors++; $display("FAIL underrun_word_count: got %0d expected %0d", rx_words.size(), exp_words);
        end
        foreach (rx_words[i]) begin
            checks++;
            if (rx_words[i] !== mem[base+i]) begin
                errors++; $display("FAIL underrun_word %0d: got %h expected %h", i, rx_words[i], mem[base+i]);
            end
        end
        checks++;
        if (done_t != exp_done) begin
            errors++; $display("FAIL underrun_done_time: got %0d expected %0d", done_t, exp_done);
        end
        checks++;
        if (cs_low != exp_done) begin
            errors++; $display("FAIL underrun_cs_low: got %0d expected %0d", cs_low, exp_done);
        end
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_flag: got %b expected 1", underrun);
        end
`else
        checks++;
        if (stall_bad != 0) begin
            errors++; $display("FAIL underrun_stall_outputs: got %0d bad cycles expected 0", stall_bad);
        end
`endif
        @(posedge RCLOCK); #2;
        checks++;
        if ({busy, burst_done} !== 2'b00) begin
            errors++; $display("FAIL underrun_after_done: got %b expected 00", {busy, burst_done});
        end
    endtask

    task automatic test_aempty_gating;
        int base;
        en = 1'b1; fifo_aempty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge RCLOCK); #2;
            checks++;
            if ({fifo_re, busy, cs_n} !== 3'b001) begin
                errors++; $display("FAIL gating_no_start cycle %0d: got %b expected 001", i, {fifo_re, busy, cs_n});
            end
        end
        base = rd_ptr;
        run_burst(1000, 0, 30);
        checks++;
        if (rx_words.size() != 4) begin
            errors++; $display("FAIL gating_word_count: got %0d expected 4", rx_words.size());
        end
        foreach (rx_words[i]) begin
            checks++;
            if (rx_words[i] !== mem[base+i]) begin
                errors++; $display("FAIL gating_word %0d: got %h expected %h", i, rx_words[i], mem[base+i]);
            end
        end
        checks++;
        if (done_t != 78) begin
            errors++; $display("FAIL gating_done_time: got %0d expected 78", done_t);
        end
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL gating_underrun_sticky: got %b expected 1", underrun);
        end
`endif
        @(posedge RCLOCK); #2;
    endtask

    task automatic test_reset_mid_shift;
        int base;
        logic exp_ready;
        logic [6:0] got;
        base = rd_ptr;
        mem[base+1] = 8'h18;
        en = 1'b1; fifo_aempty = 1'b0;
        // t=31 is bit 4 phase 1 of word 1
        for (int t = 0; t <= 31; t++) begin
            @(posedge RCLOCK); #2;
        end
        checks++;
        if ({sclk, sdo, cs_n, busy} !== 4'b1101) begin
            errors++; $display("FAIL midshift_before_reset: got %b expected 1101", {sclk, sdo, cs_n, busy});
        end
        rst = 1'b0;
        #1;
        got = {fifo_re, sclk, sdo, cs_n, busy, burst_done, ready};
        checks++;
        if (got !== 7'b0001000) begin
            errors++; $display("FAIL midshift_reset_outputs: got %b expected 0001000", got);
        end
        en = 1'b0;
        repeat (2) @(posedge RCLOCK);
        #2;
        rst = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge RCLOCK); #2;
            exp_ready = (k == 14);
            checks++;
            if (ready !== exp_ready) begin
                errors++; $display("FAIL rewarm_ready cycle %0d: got %b expected %b", k, ready, exp_ready);
            end
            checks++;
            if ({fifo_re, busy} !== 2'b00) begin
                errors++; $display("FAIL rewarm_idle cycle %0d: got %b expected 00", k, {fifo_re, busy});
            end
        end
`ifdef SPI_FIFO_BURST_UNDERRUN_ABORT_EN
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL rewarm_underrun_cleared: got %b expected 0", underrun);
        end
`endif
        base = rd_ptr;
        run_burst(1000, 0, 1000);
        checks++;
        if (rx_words.size() != 4) begin
            errors++; $display("FAIL recover_word_count: got %0d expected 4", rx_words.size());
        end
        foreach (rx_words[i]) begin
            checks++;
            if (rx_words[i] !== mem[base+i]) begin
                errors++; $display("FAIL recover_word %0d: got %h expected %h", i, rx_words[i], mem[base+i]);
            end
        end
        checks++;
        if (done_t != 78) begin
            errors++; $display("FAIL recover_done_time: got %0d expected 78", done_t);
        end
        @(posedge RCLOCK); #2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'((i * 37 + 11) & 255);
        mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h01;
        mem[4] = 8'h5A; mem[5] = 8'hC3; mem[6] = 8'h81; mem[7] = 8'h7E;
        rst = 1'b0; en = 1'b1; fifo_aempty = 1'b0; fifo_empty = 1'b0;
        rst_b = 1'b0; en_b = 1'b0; aempty_b = 1'b0; empty_b = 1'b0;

        test_reset();
        test_edge_params();
        test_warmup();
        test_basic_burst();
        test_underrun();
        test_aempty_gating();
        test_reset_mid_shift();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish within 30000 cycles");
        $fatal(1);
    end

endmodule

// File: doc/spi_fifo_burst_rd.md
Name: spi_fifo_burst_rd

Overview:
Parametrised read-side burst controller between a FIFO (1-cycle registered read data) and an SPI-style serial output.
- Waits out a post-reset warm-up, then monitors FIFO almost-empty.
- Once enough data is buffered, runs a burst of BURST_WORDS words and shifts each word out MSB-first on sdo/sclk, with cs_n framing and a programmable inter-word gap.
- Replaces free-running clock gating with a synchronous, single-clock (RCLOCK) design.

Parameters:
DW, 8, FIFO word width and bits shifted per word (>=1)
BURST_WORDS, 1024, words per burst (>=1)
STARTUP_CYCLES, 14, RCLOCK cycles after reset before the first burst may start (0 = none)
GAP_CYCLES, 1, idle RCLOCK cycles between words inside a burst; sclk low, cs_n low (0 = no gap)

Ports:
RCLOCK  in  1  block clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  burst start permit, sampled in IDLE only
fifo_aempty  in  1  FIFO almost-empty flag
fifo_empty  in  1  FIFO empty flag
fifo_q  in  DW  FIFO read data, valid the cycle after fifo_re
fifo_re  out  1  FIFO read enable
sclk  out  1  serial clock, registered
sdo  out  1  serial data, registered
cs_n  out  1  frame select, active low, registered
busy  out  1  high from burst start until DONE exits
burst_done  out  1  single-cycle pulse on burst completion
ready  out  1  warm-up complete

Behaviour:
- Reset values (rst low, asynchronous):
  - state=WARMUP; all counters 0; shift register 0.
  - sclk=0, sdo=0, cs_n=1, busy=0, burst_done=0, ready=0, fifo_re=0.
  - Reset mid-burst aborts immediately. No FIFO read is issued after rst deasserts until the next start condition.
- States: WARMUP, IDLE, READ, LOAD, SHIFT, GAP, DONE.
- WARMUP:
  - Counts STARTUP_CYCLES, then goes to IDLE and sets ready=1.
  - ready stays 1 until reset.
  - STARTUP_CYCLES=0: IDLE on the first clock after reset.
- IDLE -> READ when en=1 and fifo_aempty=0.
  - Same edge: busy=1, cs_n=0, word counter=0.
- READ:
  - fifo_re = (state==READ) && !fifo_empty (combinational from the registered state).
  - Leaves for LOAD only on a cycle where fifo_empty=0.
  - Otherwise stalls in READ: sclk=0, cs_n=0, no read issued.
- LOAD: captures fifo_q into the DW-bit shift register, then goes to SHIFT.
- SHIFT lasts exactly 2*DW cycles, two phases per bit, MSB first:
  - Phase 0: sclk=0, sdo=current bit.
  - Phase 1: sclk=1, sdo held.
  - sdo changes only while sclk is low; receiver samples on sclk rising.
- After the last bit, the word counter increments:
  - Counter == BURST_WORDS -> DONE.
  - Otherwise -> GAP, or -> READ if GAP_CYCLES=0.
- GAP: sclk=0, cs_n=0 for GAP_CYCLES cycles, then READ.
- DONE lasts 1 cycle: burst_done=1, cs_n=1, busy=0 on exit, -> IDLE.
  - A new burst may start on the next IDLE cycle.
- Timing:
  - Per-word cost = 1 (READ) + 1 (LOAD) + 2*DW (SHIFT) + GAP_CYCLES; the last word has no gap.
  - Stall cycles add to this.
- Counter widths:
  - Word counter: $clog2(BURST_WORDS+1).
  - Bit/phase counter: $clog2(2*DW).
  - Warm-up/gap counter: sized to the larger of STARTUP_CYCLES and GAP_CYCLES, min 1 bit.
  - No counter wraps within a burst.
- Input sampling:
  - fifo_aempty and en are ignored outside IDLE.
  - fifo_aempty returning high mid-burst does not end the burst.

Optional Feature:
Macro SPI_FIFO_BURST_UNDERRUN_ABORT_EN.
- Defined:
  - fifo_empty=1 in READ aborts the burst: goes to DONE with no read.
  - Adds output port underrun (1 bit), a sticky flag set on abort and cleared only by reset.
  - burst_done still pulses.
- Undefined:
  - READ stalls indefinitely until data arrives.
  - Port underrun is absent.

Test Plan:
- Warm-up: STARTUP_CYCLES=14, fifo_aempty=0, en=1 from reset -> ready rises and IDLE is entered after 14 cycles; first fifo_re 1 cycle later; no fifo_re before.
- Basic burst: DW=8, BURST_WORDS=4, GAP_CYCLES=2, FIFO words 0xA5,0x3C,0xFF,0x01 -> 4 fifo_re pulses 20 cycles apart; sdo bits 10100101 sampled on 8 sclk rises per word; cs_n low 4*18+3*2=78 cycles; burst_done pulses once; busy falls.
- Underrun stall (macro off): fifo_empty=1 for 5 cycles before word 3 -> READ held 5 extra cycles, sclk=0, cs_n=0; data is still exact and in order afterwards.
- Underrun abort (macro on): same stimulus -> burst ends after 2 words, burst_done=1, underrun=1 and stays 1 across a later good burst.
- Reset mid-SHIFT: rst low at bit 4 of word 1 -> cs_n=1, sclk=0, sdo=0, busy=0 immediately; after release, WARMUP repeats.
- Edge parameters: GAP_CYCLES=0, BURST_WORDS=1, DW=1; en=0 with fifo_aempty=0 -> no start; en=1 -> exactly one 4-cycle word (READ, LOAD, 2 SHIFT), then DONE.
